// File: rtl/keypad_scan_ctrl_pkg.sv
// keypad_pkg: shared types and constants for the 4x4 keypad scan controller.
//   state_e     : scan FSM states
//   COL_RESET   : column drive after reset (column 0 driven low)
//   col_drive() : column index -> one-cold column drive
//   key_map()   : (row, column) -> 4-bit key code
//   single_low(): true when exactly one row line is low
//   low_index() : index of the low row line (meaningful only when single_low)
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_e;

    localparam logic [3:0] COL_RESET = 4'b1110;

    function automatic logic [3:0] col_drive(input logic [1:0] col);
        logic [3:0] drv;
        case (col)
            2'd0:    drv = COL_RESET;
            2'd1:    drv = 4'b1101;
            2'd2:    drv = 4'b1011;
            default: drv = 4'b0111;
        endcase
        return drv;
    endfunction

    function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'b00_00: code = 4'h1;
            4'b00_01: code = 4'h2;
            4'b00_10: code = 4'h3;
            4'b00_11: code = 4'hA;
            4'b01_00: code = 4'h4;
            4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h6;
            4'b01_11: code = 4'hB;
            4'b10_00: code = 4'h7;
            4'b10_01: code = 4'h8;
            4'b10_10: code = 4'h9;
            4'b10_11: code = 4'hC;
            4'b11_00: code = 4'hE;
            4'b11_01: code = 4'h0;
            4'b11_10: code = 4'hF;
            default:  code = 4'hD;
        endcase
        return code;
    endfunction

    function automatic logic single_low(input logic [3:0] rows);
        logic one;
        case (rows)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: one = 1'b1;
            default:                            one = 1'b0;
        endcase
        return one;
    endfunction

    function automatic logic [1:0] low_index(input logic [3:0] rows);
        logic [1:0] idx;
        case (rows)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            default: idx = 2'd3;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scan_ctrl_if.sv
// keypad_scan_ctrl_if: keypad pins plus the key event outputs.
//   keypad_hori : raw row lines, active-low, asynchronous (into controller)
//   keypad_vert : one-cold column drive (from controller)
//   key_code    : last accepted key
//   key_valid   : one-cycle pulse per accepted key
//   key_held    : accepted key still down
// master = controller side, slave = keypad/consumer side.
interface keypad_scan_ctrl_if;
    logic [3:0] keypad_hori;
    logic [3:0] keypad_vert;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    modport master (
        input  keypad_hori,
        output keypad_vert,
        output key_code,
        output key_valid,
        output key_held
    );

    modport slave (
        output keypad_hori,
        input  keypad_vert,
        input  key_code,
        input  key_valid,
        input  key_held
    );
endinterface

// File: rtl/keypad_scan_ctrl_row_sync.sv
// row_sync: 2-flop synchronizer for the asynchronous row lines.
//   clk    : scan clock
//   reset  : synchronous active-high reset, outputs idle rows (all high)
//   rows_i : raw row lines
//   rows_o : synchronized row lines
module row_sync (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows_i,
    output logic [3:0] rows_o
);
    logic [3:0] ff1_q;
    logic [3:0] ff2_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            ff1_q <= 4'b1111;
            ff2_q <= 4'b1111;
        end else begin
            ff1_q <= rows_i;
            ff2_q <= ff1_q;
        end
    end

    assign rows_o = ff2_q;
endmodule

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: 4x4 keypad column scanner with press/release debounce.
//   clk   : scan clock
//   reset : synchronous active-high reset
//   kp    : keypad_scan_ctrl_if.master (rows in, columns/key events out)
// Parameters:
//   SETTLE_CYCLES    : cycles per column slot (>= 3)
//   DEBOUNCE_SAMPLES : consecutive matching samples to accept press/release (>= 1)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// SCAN     | rotating columns, looking for a single low row
// DEBOUNCE | column frozen, counting matching press samples
// HELD     | key accepted, waiting for its row to go high
// RELEASE  | column frozen, counting high samples of the latched row
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int SETTLE_CYCLES    = 8,
    parameter int DEBOUNCE_SAMPLES = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    keypad_scan_ctrl_if.master   kp
);
    localparam int SLOT_W = $clog2(SETTLE_CYCLES);
    localparam int CNT_W  = $clog2(DEBOUNCE_SAMPLES + 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(DEBOUNCE_SAMPLES);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    state_e             state_q, state_d;
    logic [1:0]         col_q, col_d;
    logic [1:0]         row_q, row_d;
    logic [SLOT_W-1:0]  slot_q, slot_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         code_q, code_d;
    logic               valid_q, valid_d;

    logic [3:0]         rows_s;
    logic               sample;
    logic               press_ok;
    logic [1:0]         press_row;
    logic [CNT_W-1:0]   cnt_inc;

    row_sync u_row_sync (
        .clk    (clk),
        .reset  (reset),
        .rows_i (kp.keypad_hori),
        .rows_o (rows_s)
    );

    assign sample    = (slot_q == SLOT_LAST);
    assign press_ok  = single_low(rows_s);
    assign press_row = low_index(rows_s);
    // Saturating so a long DEBOUNCE_SAMPLES-limited count never wraps.
    assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        valid_d = 1'b0;
        // Slot counter free-runs while frozen; a column change always lands on a wrap.
        slot_d  = sample ? '0 : slot_q + 1'b1;

        if (sample) begin
            case (state_q)
                SCAN: begin
                    if (press_ok) begin
                        row_d = press_row;
                        cnt_d = CNT_ONE;
                        if (DEBOUNCE_SAMPLES == 1) begin
                            code_d  = key_map(press_row, col_q);
                            valid_d = 1'b1;
                            state_d = HELD;
                        end else begin
                            state_d = DEBOUNCE;
                        end
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (press_ok && (press_row == row_q)) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_MAX) begin
                            code_d  = key_map(row_q, col_q);
                            valid_d = 1'b1;
                            state_d = HELD;
                        end
                    end else begin
                        cnt_d   = '0;
                        state_d = SCAN;
                        col_d   = col_q + 2'd1;
                    end
                end
                HELD: begin
                    // Only the latched row matters; other keys in this column are ignored.
                    if (rows_s[row_q]) begin
                        if (DEBOUNCE_SAMPLES == 1) begin
                            cnt_d   = '0;
                            state_d = SCAN;
                            col_d   = col_q + 2'd1;
                        end else begin
                            cnt_d   = CNT_ONE;
                            state_d = RELEASE;
                        end
                    end
                end
                RELEASE: begin
                    if (rows_s[row_q]) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_MAX) begin
                            cnt_d   = '0;
                            state_d = SCAN;
                            col_d   = col_q + 2'd1;
                        end
                    end else begin
                        state_d = HELD;
                    end
                end
                default: begin
                    state_d = SCAN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= SCAN;
            col_q   <= 2'd0;
            row_q   <= 2'd0;
            slot_q  <= '0;
            cnt_q   <= '0;
            code_q  <= 4'h0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            slot_q  <= slot_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            valid_q <= valid_d;
        end
    end

    assign kp.keypad_vert = col_drive(col_q);
    assign kp.key_code    = code_q;
    assign kp.key_valid   = valid_q;
    assign kp.key_held    = (state_q == HELD) || (state_q == RELEASE);
endmodule

// File: tb/tb_keypad_scan_ctrl.sv
module tb_keypad_scan_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] down = 16'h0;   // bit r*4+c set = key at row r, column c pressed
    logic [3:0]  hori_drv;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;

    always #5 clk = ~clk;

    keypad_scan_ctrl_if kp ();

    keypad_scan_ctrl #(
        .SETTLE_CYCLES    (8),
        .DEBOUNCE_SAMPLES (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .kp    (kp.master)
    );

    // Passive keypad model: a pressed key shorts its column to its row.
    always_comb begin
        hori_drv = 4'hF;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (!kp.keypad_vert[c] && down[r*4+c]) hori_drv[r] = 1'b0;
    end
    assign kp.keypad_hori = hori_drv;

    function automatic logic [3:0] exp_vert(input int c);
        case (c)
            0:       return 4'b1110;
            1:       return 4'b1101;
            2:       return 4'b1011;
            default: return 4'b0111;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    // Leaves the bench at the negedge of cycle 0 (first cycle after reset).
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        cyc = 0;
    endtask

    task automatic test_reset();
        down = 16'h0;
        do_reset();
        total++; if (kp.keypad_vert !== 4'b1110) begin bad++; $display("FAIL reset_vert: got %b want 1110", kp.keypad_vert); end
        total++; if (kp.key_code !== 4'h0) begin bad++; $display("FAIL reset_code: got %h want 0", kp.key_code); end
        total++; if (kp.key_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", kp.key_valid); end
        total++; if (kp.key_held !== 1'b0) begin bad++; $display("FAIL reset_held: got %b want 0", kp.key_held); end
    endtask

    task automatic test_idle_scan();
        down = 16'h0;
        do_reset();
        while (cyc < 64) begin
            total++; if (kp.keypad_vert !== exp_vert((cyc / 8) % 4)) begin bad++; $display("FAIL idle_vert cyc=%0d: got %b want %b", cyc, kp.keypad_vert, exp_vert((cyc / 8) % 4)); end
            total++; if (kp.key_valid !== 1'b0) begin bad++; $display("FAIL idle_valid cyc=%0d: got %b want 0", cyc, kp.key_valid); end
            step();
        end
    endtask

    task automatic test_press_5();
        int pulses = 0;
        down = 16'h0;
        do_reset();
        down[1*4+1] = 1'b1;
        while (cyc <= 112) begin
            if (kp.key_valid === 1'b1) begin
                pulses++;
                total++; if (cyc != 40) begin bad++; $display("FAIL p5_valid_cycle: got %0d want 40", cyc); end
                total++; if (kp.key_code !== 4'h5) begin bad++; $display("FAIL p5_code: got %h want 5", kp.key_code); end
                total++; if (kp.key_held !== 1'b1) begin bad++; $display("FAIL p5_held_rise: got %b want 1", kp.key_held); end
            end
            if (cyc == 30) begin
                total++; if (kp.keypad_vert !== 4'b1101) begin bad++; $display("FAIL p5_frozen: got %b want 1101", kp.keypad_vert); end
            end
            if (cyc == 80) begin
                total++; if (kp.key_code !== 4'h5) begin bad++; $display("FAIL p5_code_stable: got %h want 5", kp.key_code); end
                total++; if (pulses != 1) begin bad++; $display("FAIL p5_pulses: got %0d want 1", pulses); end
                down = 16'h0;
            end
            if (cyc == 111) begin
                total++; if (kp.key_held !== 1'b1) begin bad++; $display("FAIL p5_held_before_rel: got %b want 1", kp.key_held); end
            end
            if (cyc == 112) begin
                total++; if (kp.key_held !== 1'b0) begin bad++; $display("FAIL p5_held_fall: got %b want 0", kp.key_held); end
                total++; if (kp.keypad_vert !== 4'b1011) begin bad++; $display("FAIL p5_resume_vert: got %b want 1011", kp.keypad_vert); end
            end
            step();
        end
        total++; if (pulses != 1) begin bad++; $display("FAIL p5_total_pulses: got %0d want 1", pulses); end
    endtask

    task automatic test_short_press();
        int pulses = 0;
        down = 16'h0;
        do_reset();
        down[1*4+1] = 1'b1;
        while (cyc <= 50) begin
            if (kp.key_valid === 1'b1) pulses++;
            if (cyc == 32) down = 16'h0;
            if (cyc == 39) begin
                total++; if (kp.keypad_vert !== 4'b1101) begin bad++; $display("FAIL short_frozen: got %b want 1101", kp.keypad_vert); end
            end
            if (cyc == 40) begin
                total++; if (kp.keypad_vert !== 4'b1011) begin bad++; $display("FAIL short_resume: got %b want 1011", kp.keypad_vert); end
            end
            if (cyc == 48) begin
                total++; if (kp.keypad_vert !== 4'b0111) begin bad++; $display("FAIL short_next_col: got %b want 0111", kp.keypad_vert); end
            end
            step();
        end
        total++; if (pulses != 0) begin bad++; $display("FAIL short_pulses: got %0d want 0", pulses); end
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        down = 16'h0;
        do_reset();
        down[3*4+3] = 1'b1;
        while (cyc <= 380) begin
            if (kp.key_valid === 1'b1) begin
                total++; if (cyc != ((pulses == 0) ? 56 : 352)) begin bad++; $display("FAIL d_valid_cycle%0d: got %0d want %0d", pulses, cyc, (pulses == 0) ? 56 : 352); end
                total++; if (kp.key_code !== 4'hD) begin bad++; $display("FAIL d_code%0d: got %h want d", pulses, kp.key_code); end
                pulses++;
            end
            if (cyc == 100) begin
                total++; if (kp.key_held !== 1'b1) begin bad++; $display("FAIL d_held: got %b want 1", kp.key_held); end
            end
            if (cyc == 232) down = 16'h0;
            if (cyc == 264) begin
                total++; if (kp.keypad_vert !== 4'b1110) begin bad++; $display("FAIL d_resume_vert: got %b want 1110", kp.keypad_vert); end
            end
            if (cyc == 280) begin
                total++; if (kp.key_held !== 1'b0) begin bad++; $display("FAIL d_held_gap: got %b want 0", kp.key_held); end
            end
            if (cyc == 300) down[3*4+3] = 1'b1;
            step();
        end
        total++; if (pulses != 2) begin bad++; $display("FAIL d_pulses: got %0d want 2", pulses); end
        down = 16'h0;
    endtask

    task automatic test_multi_key();
        int pulses = 0;
        down = 16'h0;
        do_reset();
        down[0*4+0] = 1'b1;
        down[2*4+0] = 1'b1;
        while (cyc < 64) begin
            if (kp.key_valid === 1'b1) pulses++;
            total++; if (kp.keypad_vert !== exp_vert((cyc / 8) % 4)) begin bad++; $display("FAIL multi_vert cyc=%0d: got %b want %b", cyc, kp.keypad_vert, exp_vert((cyc / 8) % 4)); end
            step();
        end
        total++; if (pulses != 0) begin bad++; $display("FAIL multi_pulses: got %0d want 0", pulses); end
        down = 16'h0;
    endtask

    task automatic test_reset_in_held();
        int pulses = 0;
        down = 16'h0;
        do_reset();
        down[2*4+2] = 1'b1;
        while (cyc < 60) begin
            if (kp.key_valid === 1'b1) begin
                pulses++;
                total++; if (cyc != 48) begin bad++; $display("FAIL r9_valid_cycle: got %0d want 48", cyc); end
            end
            step();
        end
        total++; if (kp.key_held !== 1'b1) begin bad++; $display("FAIL r9_held: got %b want 1", kp.key_held); end
        total++; if (kp.key_code !== 4'h9) begin bad++; $display("FAIL r9_code: got %h want 9", kp.key_code); end
        reset = 1'b1;
        down = 16'h0;
        @(posedge clk);
        @(negedge clk);
        total++; if (kp.keypad_vert !== 4'b1110) begin bad++; $display("FAIL r9_rst_vert: got %b want 1110", kp.keypad_vert); end
        total++; if (kp.key_code !== 4'h0) begin bad++; $display("FAIL r9_rst_code: got %h want 0", kp.key_code); end
        total++; if (kp.key_held !== 1'b0) begin bad++; $display("FAIL r9_rst_held: got %b want 0", kp.key_held); end
        total++; if (kp.key_valid !== 1'b0) begin bad++; $display("FAIL r9_rst_valid: got %b want 0", kp.key_valid); end
        reset = 1'b0;
        cyc = 0;
        while (cyc < 20) begin
            if (kp.key_valid === 1'b1) pulses++;
            step();
        end
        total++; if (pulses != 1) begin bad++; $display("FAIL r9_pulses: got %0d want 1", pulses); end
    endtask

    initial begin
        test_reset();
        test_idle_scan();
        test_press_5();
        test_short_press();
        test_back_to_back();
        test_multi_key();
        test_reset_in_held();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/keypad_scan_ctrl.md
# keypad_scan_ctrl

Scan controller for the 4x4 matrix keypad. It drives the four column lines one at a time and samples the four row lines through an internal synchronizer. It debounces press and release, and emits exactly one key event per physical press. It sits between the keypad pins and the digit-storage/display path, and sequences the keypad as a shared resource: while a key is being debounced or held, scanning freezes on that key's column.

## Interface
- SETTLE_CYCLES, default 8: cycles per column slot. Must be ≥3 to cover synchronizer latency plus line settling.
- DEBOUNCE_SAMPLES, default 4: consecutive matching samples needed to accept a press or a release. Must be ≥1.
- clk  in  1  keypad scan clock (the divided keypad clock in the top level).
- reset  in  1  one clock; reset is synchronous and active-high; returns all state to reset values on the next clk edge.
- keypad_hori  in  4  raw row lines, active-low (pulled up; a pressed key pulls its row low). Asynchronous to clk.
- keypad_vert  out  4  column drive, one-cold (exactly one bit low).
- key_code  out  4  hex value of the last accepted key; holds until the next accepted key.
- key_valid  out  1  one-cycle pulse when a new key is accepted.
- key_held  out  1  high while the accepted key is still down (HELD or RELEASE state).

## Operation
- keypad_hori passes through a 2-flop synchronizer; every "sample" below refers to the synchronized rows.
- Slot counter runs 0..SETTLE_CYCLES-1. A sample is taken on the cycle where slot counter = SETTLE_CYCLES-1.
- Valid press sample: exactly one row bit low. Zero or ≥2 rows low counts as no press, so multi-key presses in the active column are ignored.
- Key map (row r, column c → code):
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: E 0 F D
- FSM states:
  - SCAN:
    - Valid press sample → latch the row, cnt=1, go to DEBOUNCE.
    - If DEBOUNCE_SAMPLES=1 instead: accept immediately and go to HELD.
    - Otherwise advance the column (c+1 mod 4, wrapping 3→0).
  - DEBOUNCE (column frozen):
    - Sample with the same single row low → cnt++.
    - When cnt reaches DEBOUNCE_SAMPLES → accept and go to HELD.
    - Any other sample → go to SCAN and advance the column.
  - HELD (column frozen):
    - Latched row high in a sample → cnt=1, go to RELEASE (or go directly to SCAN if DEBOUNCE_SAMPLES=1).
    - Other rows in the same column are ignored.
  - RELEASE:
    - Latched row high → cnt++.
    - When cnt reaches DEBOUNCE_SAMPLES → go to SCAN and advance the column.
    - Latched row low again → go back to HELD with no new event.
- Accept: key_code ← map(row, column); key_valid pulses once.
- cnt width is $clog2(DEBOUNCE_SAMPLES+1). It saturates and never wraps.

## Timing
- Reset values:
  - keypad_vert = 4'b1110 (column 0)
  - key_code = 0, key_valid = 0, key_held = 0
  - state SCAN, slot counter 0, cnt 0
- Column change: keypad_vert updates on the clk edge after the sample cycle, and the slot counter restarts at 0 on that same edge.
- Slot length: in SCAN with no press, each column is driven for exactly SETTLE_CYCLES cycles, so a full scan takes 4·SETTLE_CYCLES.
- Press latency:
  - First qualifying sample at cycle T → key_valid high during cycle T+(DEBOUNCE_SAMPLES-1)·SETTLE_CYCLES+1.
  - key_code is valid in the same cycle as key_valid and stays stable afterward.
  - key_held rises in the same cycle as key_valid.
- Release latency: key_held falls on the edge where RELEASE exits to SCAN.
- Reset mid-debounce or mid-hold: no key_valid pulse, outputs take reset values, and scanning restarts at column 0.
- Reset wins over any event that would fire on the same edge.

## Structure
- Package keypad_pkg holds:
  - the state enum (SCAN, DEBOUNCE, HELD, RELEASE)
  - the KEY_MAP constant/function (row, column → 4-bit code)
  - the COL_RESET constant 4'b1110
- One sub-module, row_sync: a 2-flop synchronizer with reset to 4'b1111.
- Everything else (FSM, slot counter, debounce counter, column register) lives in keypad_scan_ctrl.

## Test plan
Defaults SETTLE_CYCLES=8, DEBOUNCE_SAMPLES=4.
- Idle rows 4'b1111 for 64 cycles after reset → keypad_vert cycles 1110→1101→1011→0111→1110, 8 cycles each; key_valid never asserts.
- Hold row1 low whenever column1 is driven (key '5') → keypad_vert freezes at 1101; one key_valid pulse with key_code=4'h5 exactly 25 cycles after the first qualifying sample; key_held=1.
- Press '5' for only 3 samples, then release → no key_valid; scanning resumes at column 2 (1011).
- Hold 'D' (row3, column3) for 200 cycles, release for 4 samples, then press again → exactly two key_valid pulses, both with key_code=4'hD; key_held drops between them.
- Rows 0 and 2 low together in column 0 → no key_valid; scanning continues unfrozen.
- Assert reset during HELD for key '9' → next cycle keypad_vert=1110, key_code=0, key_held=0, no pulse.
